uart_tx_fifo: RTL and testbench

Byte buffer and transmit sequencer between the AHB-Lite UART register interface and the UART_TX serializer. The CPU pushes bytes back-to-back without polling the TX busy flag. The block drains them one at a time into the serializer using a start-pulse / busy handshake. It also reports fill level, sticky errors and interrupt-ready status flags.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo_sync_fifo.sv | 82 ++++++++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit buffer slice.
package uart_pkg;

  // Default serializer byte width.
  localparam int unsigned UART_DATA_W = 8;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous register-array FIFO with flush and a full-FIFO push/pop
// pass-through. A push in the same cycle as a flush is discarded.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = UART_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     pop_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  drop_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Accept/drop decisions: a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && !flush_i && (!full_o || pop_ok);
    drop_o  = push_i && !flush_i && full_o && !pop_ok;
  end

  // Pointer and occupancy next state; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and transmit sequencer feeding the UART serializer through a
// start-pulse / busy handshake, with fill-level, sticky-error and irq flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned DATA_W       = UART_DATA_W,
  parameter int unsigned LOW_WM       = 2,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                RSTn,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                flush,
  input  logic                clr_err,
  input  logic                tx_busy,
  output logic                tx_en,
  output logic [DATA_W-1:0]   tx_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty,
  output logic                irq_low,
  output logic                irq_done,
  output logic                ovf_err,
  output logic                tmo_err
);

  localparam int unsigned TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0]   LOW_CNT  = (DEPTH_LOG2 + 1)'(LOW_WM);

  tx_state_e         state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q;
  logic              ovf_q, tmo_q;

  logic              pop;
  logic              tmo_hit;
  logic              fifo_drop;
  logic [DATA_W-1:0] fifo_rd_data;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (RSTn),
    .flush_i     (flush),
    .push_i      (wr_en),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_rd_data),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .drop_o      (fifo_drop)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (pop) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)      state_d = ST_WAIT_DONE;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Sequencer outputs: pop strobe, timeout detection, held byte and counter next state.
  always_comb begin
    pop       = (state_q == ST_IDLE) && !empty && !tx_busy;
    tmo_hit   = (state_q == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt_q == TMO_LAST);
    tx_data_d = pop ? fifo_rd_data : tx_data_q;
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_START) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_WAIT_BUSY) && !tx_busy && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Registered start pulse is derived from the state being entered, so it is
  // high exactly for the START cycle without a combinational path to tx_en.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      tx_en_q   <= (state_d == ST_START);
      tx_data_q <= tx_data_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Sticky error flags; a new error event takes priority over a clear.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (fifo_drop)    ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (tmo_hit)      tmo_q <= 1'b1;
      else if (clr_err) tmo_q <= 1'b0;
    end
  end

  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign ovf_err  = ovf_q;
  assign tmo_err  = tmo_q;
  assign irq_low  = (count <= LOW_CNT);
  assign irq_done = empty && (state_q == ST_IDLE) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple serializer model on tx_busy.
module tb_uart_tx_fifo;

  logic       clk;
  logic       RSTn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_err;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       full, empty, irq_low, irq_done, ovf_err, tmo_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Serializer model controls and observations.
  bit          auto_busy = 1'b1;
  bit          hold_busy = 1'b0;
  int unsigned frame_len = 4;
  int unsigned busy_left = 0;
  logic [7:0]  cur_byte  = '0;
  bit          prev_en   = 1'b0;
  logic [7:0]  emitted[$];
  int unsigned en_pulses    = 0;
  int unsigned en_width_bad = 0;
  int unsigned en_busy_bad  = 0;
  int unsigned hold_bad     = 0;

  uart_tx_fifo #(
    .DEPTH_LOG2   (4),
    .DATA_W       (8),
    .LOW_WM       (2),
    .BUSY_TIMEOUT (1024)
  ) dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .clr_err  (clr_err),
    .tx_busy  (tx_busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .irq_low  (irq_low),
    .irq_done (irq_done),
    .ovf_err  (ovf_err),
    .tmo_err  (tmo_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Serializer model: acts on the falling edge, raises busy after a start pulse.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!RSTn) begin
        busy_left = 0;
        tx_busy   = 1'b0;
        prev_en   = 1'b0;
      end else begin
        if (tx_en) begin
          if (prev_en) en_width_bad++;
          if (tx_busy) en_busy_bad++;
          emitted.push_back(tx_data);
          en_pulses++;
        end
        if (busy_left > 0 && tx_data !== cur_byte) hold_bad++;
        prev_en = tx_en;
        if (hold_busy) begin
          tx_busy = 1'b1;
        end else if (busy_left > 0) begin
          busy_left--;
          tx_busy = (busy_left != 0);
        end else if (auto_busy && tx_en) begin
          busy_left = frame_len;
          cur_byte  = tx_data;
          tx_busy   = 1'b1;
        end else begin
          tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int unsigned max_cyc, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < max_cyc; i++) begin
      if (irq_done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    step();
    step();
    RSTn = 1'b1;
    step();
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (irq_low !== 1'b1) begin errors++; $display("FAIL reset_irq_low got=%b exp=1", irq_low); end
    checks++; if (irq_done !== 1'b1) begin errors++; $display("FAIL reset_irq_done got=%b exp=1", irq_done); end
    checks++; if (tx_en !== 1'b0)   begin errors++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if ({ovf_err, tmo_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got=%b exp=00", {ovf_err, tmo_err}); end
  endtask

  task automatic test_single();
    int unsigned base = emitted.size();
    int unsigned p0   = en_pulses;
    bit ok;
    frame_len = 4;
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    checks++; if (tx_en !== 1'b0)  begin errors++; $display("FAIL single_en_edge1 got=%b exp=0", tx_en); end
    checks++; if (count !== 5'd1)  begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    step();
    checks++; if (tx_en !== 1'b1)    begin errors++; $display("FAIL single_en_edge2 got=%b exp=1", tx_en); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data got=%h exp=41", tx_data); end
    checks++; if (count !== 5'd0)    begin errors++; $display("FAIL single_count_pop got=%0d exp=0", count); end
    step();
    checks++; if (tx_en !== 1'b0)  begin errors++; $display("FAIL single_en_edge3 got=%b exp=0", tx_en); end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got=irq_done 0 exp=1 within 100 cycles"); end
    checks++; if (en_pulses - p0 != 1 || emitted.size() != base + 1 || emitted[base] !== 8'h41)
      begin errors++; $display("FAIL single_emit got_pulses=%0d exp=1", en_pulses - p0); end
  endtask

  task automatic test_fill_overflow();
    int unsigned base;
    bit ok;
    hold_busy = 1'b1;
    step();
    base = emitted.size();
    for (int unsigned i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      step();
      if (i == 1) begin
        checks++; if (irq_low !== 1'b1) begin errors++; $display("FAIL wm_at2 got=%b exp=1", irq_low); end
      end
      if (i == 2) begin
        checks++; if (irq_low !== 1'b0) begin errors++; $display("FAIL wm_at3 got=%b exp=0", irq_low); end
      end
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1)    begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 5'd16)  begin errors++; $display("FAIL fill_count got=%0d exp=16", count); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got=%b exp=0", ovf_err); end
    // 17th push with a same-cycle clear: the drop must still set the flag.
    wr_en = 1'b1; wr_data = 8'h99; clr_err = 1'b1;
    step();
    wr_en = 1'b0; clr_err = 1'b0;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
    checks++; if (count !== 5'd16)  begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
    hold_busy = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fill_drain got=irq_done 0 exp=1 within 2000 cycles"); end
    checks++; if (emitted.size() != base + 16) begin errors++; $display("FAIL fill_nbytes got=%0d exp=16", emitted.size() - base); end
    for (int unsigned i = 0; i < 16 && base + i < emitted.size(); i++) begin
      checks++; if (emitted[base + i] !== 8'(i + 1))
        begin errors++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, emitted[base + i], 8'(i + 1)); end
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf_err); end
  endtask

  task automatic test_full_push_pop();
    int unsigned base;
    bit ok;
    hold_busy = 1'b1;
    step();
    base = emitted.size();
    for (int unsigned i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL pp_pre_count got=%0d exp=16", count); end
    hold_busy = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'hB0;
    step();
    wr_en = 1'b0;
    checks++; if (tx_en !== 1'b1)   begin errors++; $display("FAIL pp_popped got=%b exp=1", tx_en); end
    checks++; if (count !== 5'd16)  begin errors++; $display("FAIL pp_count got=%0d exp=16", count); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%b exp=0", ovf_err); end
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pp_drain got=irq_done 0 exp=1 within 2000 cycles"); end
    checks++; if (emitted.size() != base + 17) begin errors++; $display("FAIL pp_nbytes got=%0d exp=17", emitted.size() - base); end
    else begin
      checks++; if (emitted[base] !== 8'hA0)      begin errors++; $display("FAIL pp_first got=%h exp=a0", emitted[base]); end
      checks++; if (emitted[base + 16] !== 8'hB0) begin errors++; $display("FAIL pp_last got=%h exp=b0", emitted[base + 16]); end
    end
  endtask

  task automatic test_timeout();
    int unsigned p0 = en_pulses;
    bit early = 1'b0;
    auto_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    for (int unsigned i = 0; i < 1025; i++) begin
      step();
      if (tmo_err !== 1'b0 || irq_done !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL tmo_early got=flag or idle before 1024 wait cycles exp=none"); end
    step();
    checks++; if (tmo_err !== 1'b1)  begin errors++; $display("FAIL tmo_set got=%b exp=1", tmo_err); end
    checks++; if (irq_done !== 1'b1) begin errors++; $display("FAIL tmo_idle got=%b exp=1", irq_done); end
    checks++; if (en_pulses - p0 != 1) begin errors++; $display("FAIL tmo_pulses got=%0d exp=1", en_pulses - p0); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_clear got=%b exp=0", tmo_err); end
    auto_busy = 1'b1;
  endtask

  task automatic test_flush();
    int unsigned base = emitted.size();
    int unsigned p0;
    bit ok;
    frame_len = 20;
    for (int unsigned i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h61 + 8'(i);
      step();
    end
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL flush_pre_count got=%0d exp=4", count); end
    p0 = en_pulses;
    flush = 1'b1; wr_data = 8'h77;
    step();
    flush = 1'b0; wr_en = 1'b0;
    checks++; if (count !== 5'd0)   begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b exp=0", ovf_err); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_inflight got=irq_done 0 exp=1 within 200 cycles"); end
    repeat (5) step();
    checks++; if (en_pulses != p0) begin errors++; $display("FAIL flush_no_tx got=%0d exp=0 new pulses", en_pulses - p0); end
    checks++; if (emitted.size() != base + 1 || emitted[base] !== 8'h61)
      begin errors++; $display("FAIL flush_emit got=%0d bytes exp=1 byte 61", emitted.size() - base); end
  endtask

  task automatic test_reset_midframe();
    int unsigned p0;
    bit seen = 1'b0;
    frame_len = 20;
    hold_busy = 1'b1;
    step();
    for (int unsigned i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf got=%b exp=1", ovf_err); end
    hold_busy = 1'b0;
    step();
    for (int unsigned i = 0; i < 20; i++) begin
      if (tx_busy) begin seen = 1'b1; break; end
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_busy_rise got=0 exp=1 within 20 cycles"); end
    step();
    RSTn = 1'b0;
    step();
    checks++; if (tx_en !== 1'b0)    begin errors++; $display("FAIL rst_tx_en got=%b exp=0", tx_en); end
    checks++; if (count !== 5'd0)    begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if ({ovf_err, tmo_err} !== 2'b00) begin errors++; $display("FAIL rst_errs got=%b exp=00", {ovf_err, tmo_err}); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    RSTn = 1'b1;
    p0 = en_pulses;
    repeat (10) step();
    checks++; if (en_pulses != p0)   begin errors++; $display("FAIL rst_quiet got=%0d exp=0 pulses", en_pulses - p0); end
    checks++; if (irq_done !== 1'b1) begin errors++; $display("FAIL rst_irq_done got=%b exp=1", irq_done); end
  endtask

  task automatic test_handshake_rules();
    checks++; if (en_width_bad != 0) begin errors++; $display("FAIL en_width got=%0d exp=0 long pulses", en_width_bad); end
    checks++; if (en_busy_bad != 0)  begin errors++; $display("FAIL en_while_busy got=%0d exp=0", en_busy_bad); end
    checks++; if (hold_bad != 0)     begin errors++; $display("FAIL data_hold got=%0d exp=0 changes", hold_bad); end
  endtask

  initial begin
    RSTn = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; clr_err = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_timeout();
    test_flush();
    test_reset_midframe();
    test_handshake_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
